// File: rtl/effect_param_sequencer.sv
// -----------------------------------------------------------------------------
// effect_param_sequencer
//
// Control-side sequencer for the bitcrush -> delay effect chain. Register
// writes from the control plane land in shadow registers and are committed to
// the live effect parameters only on audio sample boundaries. Changes that
// would click (effect enable toggles, delay length) are applied under a mute
// envelope: ramp down, apply, settle, ramp up.
//
// Ports:
//   clk              system clock
//   rst              synchronous, active-high reset
//   sample_valid     one-cycle strobe per audio sample
//   wr_valid         write request
//   wr_ready         write accepted when wr_valid && wr_ready (low only in APPLY)
//   wr_addr          0=enables, 1=bit_depth, 2=delay_samples, 3=feedback_amount
//   wr_data          write data, LSB-aligned, unused upper bits ignored
//   enable_bitcrush  live enable (enables bit 0)
//   enable_delay     live enable (enables bit 1)
//   bit_depth        live bitcrush depth
//   delay_samples    live delay length
//   feedback_amount  live feedback
//   mute_gain        output gain, 255 = unity, 0 = silent
//   busy             high whenever the sequencer is not idle
// -----------------------------------------------------------------------------
module effect_param_sequencer #(
    parameter int RAMP_STEP         = 32,
    parameter int SETTLE_SAMPLES    = 8,
    parameter int DEFAULT_BIT_DEPTH = 16,
    parameter int DEFAULT_DELAY     = 4800
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sample_valid,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [1:0]  wr_addr,
    input  logic [15:0] wr_data,
    output logic        enable_bitcrush,
    output logic        enable_delay,
    output logic [4:0]  bit_depth,
    output logic [15:0] delay_samples,
    output logic [7:0]  feedback_amount,
    output logic [7:0]  mute_gain,
    output logic        busy
);

    localparam logic [8:0]  STEP9       = 9'(RAMP_STEP);
    localparam logic [7:0]  SETTLE_LAST = 8'(SETTLE_SAMPLES - 1);
    localparam logic [4:0]  BD_RST      = 5'(DEFAULT_BIT_DEPTH);
    localparam logic [15:0] DL_RST      = 16'(DEFAULT_DELAY);

    typedef enum logic [2:0] {
        IDLE,
        RAMP_DOWN,
        APPLY,
        SETTLE,
        RAMP_UP
    } state_t;

    state_t      state, state_n;

    // Live parameters (drive the outputs directly) and their shadows.
    logic [1:0]  live_en, live_en_n;
    logic [4:0]  live_bd, live_bd_n;
    logic [15:0] live_dl, live_dl_n;
    logic [7:0]  live_fb, live_fb_n;
    logic [1:0]  sh_en, sh_en_n;
    logic [4:0]  sh_bd, sh_bd_n;
    logic [15:0] sh_dl, sh_dl_n;
    logic [7:0]  sh_fb, sh_fb_n;

    logic        soft_pend, soft_pend_n;
    logic        hard_pend, hard_pend_n;
    logic [7:0]  gain, gain_n;
    logic [7:0]  settle_cnt, settle_cnt_n;
    logic        ready_q, busy_q;

    logic        wr_fire;
    logic        soft_hit;
    logic        hard_hit;
    logic [8:0]  gain_dn;
    logic [8:0]  gain_up;

    assign wr_fire  = wr_valid && ready_q;
    assign soft_hit = wr_fire && (wr_addr == 2'd1 || wr_addr == 2'd3);
    // Enable/delay writes only need a mute ramp if they actually change the
    // live value; an equal write just refreshes the shadow.
    assign hard_hit = wr_fire &&
                      ((wr_addr == 2'd0 && wr_data[1:0] != live_en) ||
                       (wr_addr == 2'd2 && wr_data != live_dl));

    // Ramp arithmetic in 9 bits: bit 8 flags underflow (down) or overflow (up).
    assign gain_dn = {1'b0, gain} - STEP9;
    assign gain_up = {1'b0, gain} + STEP9;

    // NOTE: every signal written here gets its hold value first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_n      = state;
        live_en_n    = live_en;
        live_bd_n    = live_bd;
        live_dl_n    = live_dl;
        live_fb_n    = live_fb;
        sh_en_n      = sh_en;
        sh_bd_n      = sh_bd;
        sh_dl_n      = sh_dl;
        sh_fb_n      = sh_fb;
        soft_pend_n  = soft_pend;
        hard_pend_n  = hard_pend;
        gain_n       = gain;
        settle_cnt_n = settle_cnt;

        if (wr_fire) begin
            case (wr_addr)
                2'd0:    sh_en_n = wr_data[1:0];
                2'd1:    sh_bd_n = wr_data[4:0];
                2'd2:    sh_dl_n = wr_data;
                default: sh_fb_n = wr_data[7:0];
            endcase
        end

        case (state)
            IDLE: begin
                // Commit decisions use the shadows as they were before this
                // edge, so a same-cycle write waits for the next sample.
                if (sample_valid) begin
                    if (hard_pend) begin
                        state_n = RAMP_DOWN;
                    end else if (soft_pend) begin
                        live_bd_n   = sh_bd;
                        live_fb_n   = sh_fb;
                        soft_pend_n = 1'b0;
                    end
                end
            end
            RAMP_DOWN: begin
                if (gain == 8'd0) begin
                    state_n = APPLY;
                end else if (sample_valid) begin
                    gain_n = gain_dn[8] ? 8'd0 : gain_dn[7:0];
                end
            end
            APPLY: begin
                live_en_n    = sh_en;
                live_bd_n    = sh_bd;
                live_dl_n    = sh_dl;
                live_fb_n    = sh_fb;
                soft_pend_n  = 1'b0;
                hard_pend_n  = 1'b0;
                settle_cnt_n = 8'd0;
                state_n      = SETTLE;
            end
            SETTLE: begin
                if (sample_valid) begin
                    if (settle_cnt == SETTLE_LAST) begin
                        state_n = RAMP_UP;
                    end else begin
                        settle_cnt_n = settle_cnt + 8'd1;
                    end
                end
            end
            RAMP_UP: begin
                if (gain == 8'hFF) begin
                    state_n = IDLE;
                end else if (sample_valid) begin
                    gain_n = gain_up[8] ? 8'hFF : gain_up[7:0];
                end
            end
            default: state_n = IDLE;
        endcase

        // A new write re-arms its flag even if this edge clears it for the
        // commit in progress.
        if (soft_hit) soft_pend_n = 1'b1;
        if (hard_hit) hard_pend_n = 1'b1;
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values computed above, independent of order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            live_en    <= 2'b00;
            live_bd    <= BD_RST;
            live_dl    <= DL_RST;
            live_fb    <= 8'd0;
            sh_en      <= 2'b00;
            sh_bd      <= BD_RST;
            sh_dl      <= DL_RST;
            sh_fb      <= 8'd0;
            soft_pend  <= 1'b0;
            hard_pend  <= 1'b0;
            gain       <= 8'hFF;
            settle_cnt <= 8'd0;
            ready_q    <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            state      <= state_n;
            live_en    <= live_en_n;
            live_bd    <= live_bd_n;
            live_dl    <= live_dl_n;
            live_fb    <= live_fb_n;
            sh_en      <= sh_en_n;
            sh_bd      <= sh_bd_n;
            sh_dl      <= sh_dl_n;
            sh_fb      <= sh_fb_n;
            soft_pend  <= soft_pend_n;
            hard_pend  <= hard_pend_n;
            gain       <= gain_n;
            settle_cnt <= settle_cnt_n;
            // Handshake/status flags are registered from the next state so
            // they line up exactly with the state they describe.
            ready_q    <= (state_n != APPLY);
            busy_q     <= (state_n != IDLE);
        end
    end

    assign enable_bitcrush = live_en[0];
    assign enable_delay    = live_en[1];
    assign bit_depth       = live_bd;
    assign delay_samples   = live_dl;
    assign feedback_amount = live_fb;
    assign mute_gain       = gain;
    assign wr_ready        = ready_q;
    assign busy            = busy_q;

endmodule

// File: doc/effect_param_sequencer.md
Name: effect_param_sequencer

Overview:
- Control-side sequencer for the bitcrush→delay effect chain. Accepts register writes from the control plane (UART/MIDI decoder) into shadow registers and commits them to the live effect parameters only on audio sample boundaries.
- Changes that cause audible discontinuities (effect enable toggles, delay length) are applied under a mute envelope: ramp down, apply, settle, ramp up.
- Drives the chain's enable/parameter inputs, plus a gain word consumed by the output-stage multiplier.

Parameters:
- RAMP_STEP, 32, gain change per sample during ramps (1..255)
- SETTLE_SAMPLES, 8, muted samples held after APPLY so the delay pipeline drains (1..255)
- DEFAULT_BIT_DEPTH, 16, reset value of bit_depth
- DEFAULT_DELAY, 4800, reset value of delay_samples

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- sample_valid  in  1  one-cycle strobe per audio sample (chain input valid)
- wr_valid  in  1  write request
- wr_ready  out  1  write accepted when wr_valid && wr_ready
- wr_addr  in  2  0=enables, 1=bit_depth, 2=delay_samples, 3=feedback_amount
- wr_data  in  16  write data, LSB-aligned; unused upper bits ignored
- enable_bitcrush  out  1  live enable (enables bit 0)
- enable_delay  out  1  live enable (enables bit 1)
- bit_depth  out  5  live bitcrush depth
- delay_samples  out  16  live delay length
- feedback_amount  out  8  live feedback
- mute_gain  out  8  output gain; 255 = unity, 0 = silent
- busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (all outputs registered): enables 0; bit_depth = DEFAULT_BIT_DEPTH; delay_samples = DEFAULT_DELAY; feedback 0; mute_gain 255; busy 0; shadows equal live values; pending flags clear; state IDLE. Reset mid-ramp aborts immediately to these values.
- wr_ready = 1 in every state except APPLY.
- An accepted write updates its shadow register next cycle. Repeated writes to the same address before commit: last write wins.
- Pending flags, set on accept:
  - soft_pend: addr 1 or 3.
  - hard_pend: addr 0 or 2, and the written value differs from the current live value.
  - Writing addr 0/2 with a value equal to live sets no flag, but still updates the shadow.
- FSM states: IDLE, RAMP_DOWN, APPLY, SETTLE, RAMP_UP.
- IDLE, on sample_valid:
  - hard_pend → RAMP_DOWN.
  - else soft_pend → copy bit_depth and feedback shadows to live on the next edge, clear soft_pend, stay IDLE.
  - No sample_valid → nothing is committed.
- RAMP_DOWN: each sample_valid, mute_gain = max(mute_gain − RAMP_STEP, 0). The cycle after mute_gain becomes 0 → APPLY.
- APPLY (exactly one cycle): copy all four shadows to live, clear both pending flags, reset settle counter → SETTLE.
- SETTLE: count sample_valid; after SETTLE_SAMPLES strobes → RAMP_UP. mute_gain stays 0.
- RAMP_UP: each sample_valid, mute_gain = min(mute_gain + RAMP_STEP, 255), computed in 9 bits then saturated. The cycle after mute_gain reaches 255 → IDLE.
- Writes during RAMP_DOWN are picked up by APPLY. Writes during SETTLE/RAMP_UP set pending flags normally and are serviced after return to IDLE. No re-ramp is started mid-ramp.
- A write accepted in the same cycle as an IDLE sample_valid is not part of that commit; it is serviced at the next sample_valid.
- Only one commit decision is made per sample_valid.
- Live params change only at IDLE soft commits or in APPLY, never between.

Test Plan:
- Reset, then hold: outputs equal enables 0, bit_depth 16, delay 4800, feedback 0, mute_gain 255, busy 0, wr_ready 1.
- Write addr1=8, then addr3=0x80 (IDLE): live values unchanged until next sample_valid; one clock after it, bit_depth = 8 and feedback = 0x80; mute_gain stays 255; busy never asserts.
- Write addr0=0x3 (RAMP_STEP 32, SETTLE 8): gain across successive samples 223, 191, 159, 127, 95, 63, 31, 0. Then APPLY with wr_ready = 0 for 1 cycle and enables → 11. Then 8 muted samples. Then gain 32, 64, …, 224, 255 → IDLE, busy = 0.
- Write addr2=4800 (equal to live): no ramp; busy stays 0. Write addr2=1000: full ramp sequence; delay_samples changes only during APPLY.
- Write addr1=4 during SETTLE: bit_depth stays unchanged through RAMP_UP; it commits at the first sample_valid after IDLE.
- Assert rst during RAMP_DOWN at gain 127: next cycle mute_gain = 255, state IDLE, all params at reset defaults, pending flags clear.
